// File: rtl/fwft_fifo_pkg.sv
// Shared constants and types for the FWFT FIFO and its burst reader.
package fwft_fifo_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int FIFO_DEPTH    = 16;
    localparam int BURST_LEN_DEF = 4;
    localparam int TIMEOUT_DEF   = 16;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FLUSH} rd_state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_buffer.sv
// Purpose: generic first-word-fall-through FIFO, head word visible whenever not empty.
// Latency: a write is visible at the head on the next cycle.
// Backpressure: writes ignored when full, reads ignored when empty.
module fifo_buffer #(
    parameter int WIDTH = fwft_fifo_pkg::DATA_WIDTH,
    parameter int DEPTH = fwft_fifo_pkg::FIFO_DEPTH
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         wr_en_i,
    input  logic [WIDTH-1:0]                             wr_data_i,
    output logic                                         full_o,
    input  logic                                         rd_en_i,
    output logic [WIDTH-1:0]                             rd_data_o,
    output logic                                         empty_o,
    output logic [fwft_fifo_pkg::cnt_width(DEPTH):0]     count_o
);
    import fwft_fifo_pkg::*;

    localparam int AW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_fire;
    logic             rd_fire;

    // DEPTH is a power of two, so the extra pointer bit separates full from empty.
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (count_o == '0);
    assign full_o    = (count_o == (AW+1)'(DEPTH));
    assign rd_data_o = mem[rd_ptr_q[AW-1:0]];
    assign wr_fire   = wr_en_i && !full_o;
    assign rd_fire   = rd_en_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/idle_timer.sv
// Purpose: counts enabled idle cycles and pulses expired_o on the TIMEOUT-th one.
// Latency: expired_o is combinational on the cycle the count sits at TIMEOUT-1.
// Backpressure: none; clr_i restarts the count from zero.
module idle_timer #(
    parameter int TIMEOUT = fwft_fifo_pkg::TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    import fwft_fifo_pkg::*;

    localparam int          W        = cnt_width(TIMEOUT);
    localparam logic [W-1:0] IDLE_MAX = W'(TIMEOUT - 1);

    logic [W-1:0] idle_q;

    assign expired_o = en_i && !clr_i && (idle_q == IDLE_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            idle_q <= '0;
        end else if (en_i) begin
            idle_q <= expired_o ? '0 : idle_q + 1'b1;
        end
    end

endmodule

// File: rtl/fwft_burst_reader.sv
// Purpose: pops an FWFT FIFO into a valid/ready stream framed into BURST_LEN-beat bursts.
// Latency: pop at N, output valid at N+2; partial bursts flush TIMEOUT+2 cycles after the last pop.
// Backpressure: output register plus one lookahead slot; pops stop when both are full and stalled.
module fwft_burst_reader #(
    parameter int DATA_WIDTH = fwft_fifo_pkg::DATA_WIDTH,
    parameter int BURST_LEN  = fwft_fifo_pkg::BURST_LEN_DEF,
    parameter int TIMEOUT    = fwft_fifo_pkg::TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i
);
    import fwft_fifo_pkg::*;

    localparam int           BW        = cnt_width(BURST_LEN);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [BW-1:0]         beat_q;
    logic                  hold_valid;
    logic                  slot_free;
    logic                  end_of_burst;
    logic                  move;
    logic                  pop;
    logic                  last_now;
    logic                  idle_en;
    logic                  expired;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = S_HOLD;
            S_HOLD: begin
                if (expired)           state_d = S_FLUSH;
                else if (move && !pop) state_d = S_IDLE;
            end
            // A word arriving while flushing does not cancel the flush.
            S_FLUSH: if (move) state_d = pop ? S_HOLD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hold_valid   = (state_q != S_IDLE);
        slot_free    = !m_valid_o || m_ready_i;
        end_of_burst = (beat_q == BEAT_LAST);
        move         = hold_valid && slot_free &&
                       (end_of_burst || !fifo_empty_i || state_q == S_FLUSH);
        pop          = !rst_i && !fifo_empty_i && (!hold_valid || move);
        last_now     = end_of_burst || (state_q == S_FLUSH);
        idle_en      = (state_q == S_HOLD) && fifo_empty_i && !end_of_burst && !move;
    end

    assign fifo_rd_en_o = pop;

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!fifo_empty_i),
        .en_i      (idle_en),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)    hold_q <= '0;
        else if (pop) hold_q <= fifo_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            beat_q    <= '0;
        end else if (move) begin
            m_data_o  <= hold_q;
            m_valid_o <= 1'b1;
            m_last_o  <= last_now;
            beat_q    <= last_now ? '0 : beat_q + 1'b1;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fwft_burst_reader.sv
// Directed bench: fifo_buffer feeding fwft_burst_reader (BURST_LEN=4, TIMEOUT=16).
module tb_fwft_burst_reader;

    logic       clk = 1'b0;
    logic       fifo_rst;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_dat;
    logic       full;
    logic       rd_en;
    logic [7:0] fifo_dat;
    logic       fifo_empty;
    logic [4:0] fifo_cnt;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] out_dat  [$];
    logic       out_last [$];
    int         out_cyc  [$];
    logic [7:0] pop_dat  [$];
    int         pop_cyc  [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_buffer #(.WIDTH(8), .DEPTH(16)) u_fifo (
        .clk_i     (clk),
        .rst_i     (fifo_rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_dat),
        .full_o    (full),
        .rd_en_i   (rd_en),
        .rd_data_o (fifo_dat),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    fwft_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .TIMEOUT(16)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_data_i  (fifo_dat),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (rd_en),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_last_o     (m_last),
        .m_ready_i    (m_ready)
    );

    always @(negedge clk) begin
        if (rd_en) begin
            pop_dat.push_back(fifo_dat);
            pop_cyc.push_back(cyc);
        end
        if (m_valid && m_ready) begin
            out_dat.push_back(m_data);
            out_last.push_back(m_last);
            out_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        out_dat.delete();
        out_last.delete();
        out_cyc.delete();
        pop_dat.delete();
        pop_cyc.delete();
    endtask

    // Expected beats packed low byte first; lasts bit i belongs to beat i.
    task automatic check_stream(input string tag, input int n, input logic [63:0] dats,
                                input logic [7:0] lasts);
        check_eq({tag, "_count"}, out_dat.size(), n);
        for (int i = 0; i < n && i < out_dat.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), out_dat[i], dats[8*i +: 8]);
            check_eq($sformatf("%s_last%0d", tag, i), out_last[i], lasts[i]);
        end
    endtask

    task automatic write_words(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en  = 1'b1;
            wr_dat = base + 8'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        fifo_rst = 1'b1;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_dat   = 8'h00;
        m_ready  = 1'b1;
        step();
        step();
        fifo_rst = 1'b0;

        // 1: preload the FIFO under reset, then hold reset three more cycles.
        write_words(8'h10, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t1_rd_en%0d", i), rd_en, 0);
            check_eq($sformatf("t1_valid%0d", i), m_valid, 0);
            check_eq($sformatf("t1_last%0d", i), m_last, 0);
            check_eq($sformatf("t1_data%0d", i), m_data, 0);
            step();
        end
        check_eq("t1_fifo_cnt", fifo_cnt, 8);
        check_eq("t1_full", full, 0);
        clear_logs();

        // 2: release reset with eight words waiting.
        rst = 1'b0;
        repeat (30) step();
        check_stream("t2", 8, 64'h1716151413121110, 8'b1000_1000);
        if (out_cyc.size() == 8 && pop_cyc.size() >= 1) begin
            check_eq("t2_first_latency", out_cyc[0] - pop_cyc[0], 2);
            for (int i = 1; i < 8; i++)
                check_eq($sformatf("t2_back_to_back%0d", i), out_cyc[i] - out_cyc[0], i);
        end else begin
            check_eq("t2_log_sizes", out_cyc.size(), 8);
        end

        // 3: two-word partial burst flushed by timeout, then a fresh burst.
        clear_logs();
        write_words(8'hA0, 2);
        repeat (25) step();
        check_stream("t3a", 2, 64'h0000_0000_0000_A1A0, 8'b0000_0010);
        check_eq("t3_pop_count", pop_dat.size(), 2);
        if (out_cyc.size() == 2 && pop_cyc.size() == 2) begin
            check_eq("t3_pop_word", pop_dat[1], 8'hA1);
            check_eq("t3_flush_latency", out_cyc[1] - pop_cyc[1], 18);
        end
        clear_logs();
        write_words(8'hB0, 4);
        repeat (10) step();
        check_stream("t3b", 4, 64'h0000_0000_B3B2_B1B0, 8'b0000_1000);

        // 4: six words with a five-cycle stall while D3 sits on the output.
        clear_logs();
        write_words(8'hD0, 6);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("t4_stall_valid%0d", i), m_valid, 1);
            check_eq($sformatf("t4_stall_data%0d", i), m_data, 8'hD3);
            check_eq($sformatf("t4_stall_rd_en%0d", i), rd_en, 0);
            step();
        end
        m_ready = 1'b1;
        repeat (30) step();
        check_stream("t4", 6, 64'h0000_D5D4_D3D2_D1D0, 8'b0010_1000);
        check_eq("t4_pop_count", pop_dat.size(), 6);

        // 5: timeout fires while stalled; C0 arrives before ready returns.
        clear_logs();
        m_ready = 1'b0;
        write_words(8'hE0, 2);
        repeat (24) step();
        write_words(8'hC0, 1);
        repeat (3) step();
        check_eq("t5_no_output_while_stalled", out_dat.size(), 0);
        m_ready = 1'b1;
        write_words(8'hC1, 3);
        repeat (10) step();
        check_stream("t5", 6, 64'h0000_C3C2_C1C0_E1E0, 8'b0010_0010);

        // 6: reset after two beats; F2 (held) is discarded, F3.. remain in the FIFO.
        clear_logs();
        for (int i = 0; i < 7; i++) begin
            wr_en  = 1'b1;
            wr_dat = 8'hF0 + 8'(i);
            rst    = (i == 4 || i == 5);
            @(negedge clk);
            if (i == 4) check_eq("t6_rd_en_in_reset", rd_en, 0);
            if (i == 5) begin
                check_eq("t6_valid_after_reset", m_valid, 0);
                check_eq("t6_last_after_reset", m_last, 0);
                check_eq("t6_data_after_reset", m_data, 0);
                check_eq("t6_rd_en_after_reset", rd_en, 0);
            end
            step();
        end
        wr_en = 1'b0;
        rst   = 1'b0;
        repeat (15) step();
        check_stream("t6", 6, 64'h0000_F6F5_F4F3_F1F0, 8'b0010_0000);
        check_eq("t6_fifo_drained", fifo_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
